sync_debounce: RTL and testbench
================================

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the stability counter and of thresh.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port din  input  1  level already synchronized to clk by the upstream 2/3-flop syncer; not resampled here.
REQ-005 SHALL have port en  input  1  filter enable; 0 freezes dout and aborts any pending change.
REQ-006 SHALL have port thresh  input  CNT_W  required extra stable samples before a change is accepted.
REQ-007 SHALL have port dout  output  1  debounced level.
REQ-008 SHALL have port rise  output  1  one-cycle pulse coincident with dout 0->1.
REQ-009 SHALL have port fall  output  1  one-cycle pulse coincident with dout 1->0.
REQ-010 SHALL have port glitch  output  1  one-cycle pulse when a pending change is abandoned because din reverted.
REQ-011 SHALL have port busy  output  1  high while a change is pending (state CHECK).

Function
REQ-012 SHALL implement a two-state FSM: STABLE, CHECK; an internal counter cnt of CNT_W bits.
REQ-013 STABLE, en=1, din==dout: SHALL stay STABLE, cnt=0, no pulses.
REQ-014 STABLE, en=1, din!=dout, thresh==0: SHALL commit at that edge (dout<=din, rise/fall pulse), stay STABLE; latency 1 cycle.
REQ-015 STABLE, en=1, din!=dout, thresh!=0: SHALL go CHECK with cnt=1.
REQ-016 CHECK, en=1, din==dout: SHALL go STABLE, cnt=0, assert glitch for one cycle; dout unchanged.
REQ-017 CHECK, en=1, din!=dout, cnt>=thresh: SHALL commit (dout<=din, rise or fall for one cycle), go STABLE, cnt=0.
REQ-018 CHECK, en=1, din!=dout, cnt<thresh: SHALL increment cnt, stay CHECK.
REQ-019 A change SHALL therefore be accepted on the (thresh+1)th consecutive edge sampling din!=dout; dout registered, no combinational path din->dout.
REQ-020 cnt SHALL never exceed thresh and SHALL never wrap; thresh = 2^CNT_W-1 SHALL work without overflow.
REQ-021 thresh lowered during CHECK below current cnt SHALL cause commit at the next edge where din!=dout; thresh raised SHALL extend the wait.
REQ-022 en=0 (any state) SHALL force STABLE, cnt=0, rise/fall/glitch=0, busy=0, dout held.
REQ-023 en 0->1 SHALL resume from STABLE with the held dout; a din differing at that edge starts a fresh count.
REQ-024 rise, fall, glitch SHALL be mutually exclusive and each high at most one cycle per event; rise/fall assert in the same cycle dout changes.
REQ-025 busy SHALL equal (state==CHECK) as a registered decode.

Reset
REQ-026 rstn low SHALL asynchronously set state=STABLE, cnt=0, dout=0, rise=0, fall=0, glitch=0, busy=0, matching the upstream syncer's reset-to-0 value.
REQ-027 Reset asserted mid-CHECK SHALL discard the pending change with no glitch pulse; after release, din=1 requires a full thresh+1 samples to reach dout=1.
REQ-028 Reset release SHALL be synchronous-safe: first state update on the first rising clk edge with rstn high.

Verification
REQ-029 thresh=3, en=1, din 0->1 held 10 cycles -> dout=1 and rise=1 on the 4th edge after din change, busy high 3 cycles, then fall/glitch never asserted.
REQ-030 thresh=3, din=1 for 2 edges then back to 0 -> glitch=1 one cycle on the 3rd edge, dout stays 0, rise never asserted.
REQ-031 thresh=0, din toggles every cycle -> dout follows din delayed 1 cycle, rise/fall alternate each cycle, busy always 0.
REQ-032 CNT_W=4, thresh=15, din=1 held 20 cycles -> commit on 16th edge, cnt peaks at 15, no wrap.
REQ-033 thresh=5, din=1, en dropped to 0 at cnt=3 for 2 cycles then re-raised -> busy=0 during en=0, commit 6 edges after en rises.
REQ-034 thresh=4, rstn pulsed low at cnt=2 with din=1 -> all outputs 0 immediately, no glitch, dout=1 exactly 5 edges after rstn release.

Source files
------------

// File: rtl/sync_debounce.sv
// Debounce filter for an already-synchronized level: a change on din is accepted
// only after it has been sampled thresh+1 consecutive times; abandoned changes pulse glitch.
module sync_debounce #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             din,
    input  logic             en,
    input  logic [CNT_W-1:0] thresh,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             glitch,
    output logic             busy
);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_q, glitch_d;
    logic             busy_q, busy_d;

    // State, counter and all outputs are registered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state: cnt counts consecutive mismatching samples, saturating at thresh
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;

        if (!en) begin
            state_d = STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                STABLE: begin
                    cnt_d = '0;
                    if (din != dout_q) begin
                        if (thresh == '0) begin
                            dout_d = din;
                            rise_d = din;
                            fall_d = ~din;
                        end else begin
                            state_d = CHECK;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (din == dout_q) begin
                        state_d  = STABLE;
                        cnt_d    = '0;
                        glitch_d = 1'b1;
                    end else if (cnt_q >= thresh) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                        dout_d  = din;
                        rise_d  = din;
                        fall_d  = ~din;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == CHECK);
    end

    assign dout   = dout_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign glitch = glitch_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed and random stimulus for sync_debounce, checked against a mismatch-streak model.
module tb_sync_debounce;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rstn;
    logic             din;
    logic             en;
    logic [CNT_W-1:0] thresh;
    logic             dout;
    logic             rise;
    logic             fall;
    logic             glitch;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: dout level plus length of the current run of mismatching samples
    logic m_dout, m_rise, m_fall, m_glitch;
    int   run;

    sync_debounce #(.CNT_W(CNT_W)) u_dut (
        .clk    (clk),
        .rstn   (rstn),
        .din    (din),
        .en     (en),
        .thresh (thresh),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .glitch (glitch),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_dout"},   dout,   m_dout);
        chk({tag, "_rise"},   rise,   m_rise);
        chk({tag, "_fall"},   fall,   m_fall);
        chk({tag, "_glitch"}, glitch, m_glitch);
        chk({tag, "_busy"},   busy,   (run > 0));
    endtask

    task automatic model_reset();
        m_dout   = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_glitch = 1'b0;
        run      = 0;
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later
    task automatic step(input string tag, input logic d, input logic e, input int t);
        din    = d;
        en     = e;
        thresh = CNT_W'(t);
        @(posedge clk);
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_glitch = 1'b0;
        if (!e) begin
            run = 0;
        end else if (d == m_dout) begin
            m_glitch = (run > 0);
            run      = 0;
        end else if (run >= t) begin
            m_rise = d;
            m_fall = ~d;
            m_dout = d;
            run    = 0;
        end else begin
            run++;
        end
        #1;
        chk_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk_all(tag);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn   = 1'b1;
        din    = 1'b0;
        en     = 1'b0;
        thresh = '0;
        model_reset();
        #2;
        rstn = 1'b0;
        #1;
        chk_all("reset");
        @(negedge clk);
        rstn = 1'b1;

        // thresh=3: rise on the 4th edge, busy for 3 cycles, then return to 0
        for (int i = 0; i < 10; i++) step("th3_hold", 1'b1, 1'b1, 3);
        chk("th3_dout_final", dout, 1'b1);
        for (int i = 0; i < 6; i++) step("th3_back", 1'b0, 1'b1, 3);

        // thresh=3: two samples high then back low is a glitch
        step("gl_a", 1'b1, 1'b1, 3);
        step("gl_b", 1'b1, 1'b1, 3);
        step("gl_c", 1'b0, 1'b1, 3);
        chk("gl_pulse", glitch, 1'b1);
        step("gl_d", 1'b0, 1'b1, 3);
        chk("gl_one_cycle", glitch, 1'b0);

        // thresh=0: dout follows din one cycle late
        for (int i = 0; i < 8; i++) step("th0_toggle", 1'((i % 2) == 0), 1'b1, 0);

        // thresh=15 at CNT_W=4: commit on the 16th edge without wrapping
        step("th15_pre", 1'b0, 1'b1, 15);
        for (int i = 0; i < 20; i++) begin
            step("th15_hold", 1'b1, 1'b1, 15);
            if (i == 14) chk("th15_not_yet", dout, 1'b0);
            if (i == 15) chk("th15_commit", rise, 1'b1);
        end
        for (int i = 0; i < 18; i++) step("th15_back", 1'b0, 1'b1, 15);

        // thresh=5: enable dropped mid-count restarts the count
        for (int i = 0; i < 3; i++) step("en_cnt", 1'b1, 1'b1, 5);
        step("en_off_a", 1'b1, 1'b0, 5);
        chk("en_off_busy", busy, 1'b0);
        step("en_off_b", 1'b1, 1'b0, 5);
        for (int i = 0; i < 7; i++) begin
            step("en_resume", 1'b1, 1'b1, 5);
            if (i == 4) chk("en_not_yet", dout, 1'b0);
            if (i == 5) chk("en_commit", rise, 1'b1);
        end
        for (int i = 0; i < 7; i++) step("en_back", 1'b0, 1'b1, 5);

        // thresh=4: reset mid-count discards the pending change silently
        step("rst_a", 1'b1, 1'b1, 4);
        step("rst_b", 1'b1, 1'b1, 4);
        pulse_reset("rst_mid");
        for (int i = 0; i < 5; i++) step("rst_after", 1'b1, 1'b1, 4);
        chk("rst_dout_5th", dout, 1'b1);

        // Random phase
        begin
            logic d = din;
            int   t = 2;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 3) == 0) d = ~d;
                if ($urandom_range(0, 15) == 0)
                    t = ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 6));
                step("rand", d, 1'($urandom_range(0, 19) != 0), t);
                if ($urandom_range(0, 149) == 0) pulse_reset("rand_reset");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
